// File: rtl/sm4_dec_iter.sv
// sm4_dec_iter: iterative SM4 block decryptor, one round per clock, keys applied rk31 first.
// Optional feature macro SM4_DEC_ENC_MODE_EN adds MODE_i (1 = encrypt with rk0 first).
module sm4_dec_iter (
    input  logic         CLK_i,
    input  logic         RST_i,
    input  logic         RK_WE_i,
    input  logic [4:0]   RK_ADDR_i,
    input  logic [31:0]  RK_i,
    input  logic [127:0] DAT_i,
    input  logic         DAT_VALID_i,
    output logic         DAT_READY_o,
    output logic [127:0] DAT_o,
    output logic         DAT_VALID_o,
`ifdef SM4_DEC_ENC_MODE_EN
    input  logic         MODE_i,
`endif
    input  logic         DAT_READY_i
);
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] rk [32];
    logic [31:0] x0, x1, x2, x3;
    logic [31:0] t_in, t_out, x_new;
    logic [4:0]  r, key_idx;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[{~a, 3'b000} +: 8];
    endfunction

`ifdef SM4_DEC_ENC_MODE_EN
    logic enc;
    assign key_idx = enc ? r : ~r;
`else
    assign key_idx = ~r;
`endif

    // round datapath: Xnew = X0 ^ L(tau(X1^X2^X3^rk))
    always_comb begin
        t_in  = x1 ^ x2 ^ x3 ^ rk[key_idx];
        t_out = {sbox(t_in[31:24]), sbox(t_in[23:16]), sbox(t_in[15:8]), sbox(t_in[7:0])};
        x_new = x0 ^ t_out ^ {t_out[29:0], t_out[31:30]} ^ {t_out[21:0], t_out[31:22]}
                ^ {t_out[13:0], t_out[31:14]} ^ {t_out[7:0], t_out[31:8]};
    end

    // key file: writable only while idle, survives reset
    always_ff @(posedge CLK_i) begin
        if (RK_WE_i && state == IDLE) rk[RK_ADDR_i] <= RK_i;
    end

    // control FSM with registered handshake outputs and round state
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state       <= IDLE;
            r           <= '0;
            DAT_READY_o <= 1'b1;
            DAT_VALID_o <= 1'b0;
            DAT_o       <= '0;
        end else begin
            case (state)
                IDLE: if (DAT_VALID_i) begin
                    {x0, x1, x2, x3} <= DAT_i;
                    r                <= '0;
                    state            <= RUN;
                    DAT_READY_o      <= 1'b0;
`ifdef SM4_DEC_ENC_MODE_EN
                    enc              <= MODE_i;
`endif
                end
                RUN: begin
                    {x0, x1, x2, x3} <= {x1, x2, x3, x_new};
                    r                <= r + 5'd1;
                    if (r == 5'd31) begin
                        state       <= DONE;
                        DAT_VALID_o <= 1'b1;
                        DAT_o       <= {x_new, x3, x2, x1};
                    end
                end
                DONE: if (DAT_READY_i) begin
                    state       <= IDLE;
                    DAT_VALID_o <= 1'b0;
                    DAT_READY_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
